// File: rtl/ahb_lite_mem_slave_pkg.sv
// Shared AHB-Lite definitions: transfer types, response codes, sizes.
// Imported by the mem slave, its bus interface and the bench.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;
  localparam logic [2:0] HSIZE_BYTE  = 3'b000;

endpackage

// File: rtl/ahb_lite_mem_slave_if.sv
// AHB-Lite bus bundle: master drives address/control/wdata/hready,
// slave returns hreadyout/hrdata/hresp.
interface ahb_lite_mem_slave_if #(
  parameter int ADDR_LENGTH = 8
);

  logic                   hsel;
  logic [ADDR_LENGTH-1:0] haddr;
  logic [1:0]             htrans;
  logic                   hwrite;
  logic [2:0]             hsize;
  logic [2:0]             hburst;
  logic [3:0]             hprot;
  logic [7:0]             hwdata;
  logic                   hready;
  logic                   hreadyout;
  logic [7:0]             hrdata;
  logic                   hresp;

  modport master (
    output hsel, haddr, htrans, hwrite,
    output hsize, hburst, hprot, hwdata,
    input  hready, hreadyout, hrdata, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite,
    input  hsize, hburst, hprot, hwdata,
    input  hready,
    output hreadyout, hrdata, hresp
  );

endinterface

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite byte-memory responder with programmable wait states and ERROR.
// Ports: clk, rst_n (async, active-low), io_ahb (slave modport).
module ahb_lite_mem_slave
  import ahb_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int MEM_DEPTH   = 16,
  parameter int ADDR_LENGTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ahb_lite_mem_slave_if.slave  io_ahb
);

  localparam int AW =
    (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_LENGTH:0] LP_DEPTH =
    (ADDR_LENGTH+1)'(MEM_DEPTH);
  localparam logic [2:0] LP_WLOAD =
    3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_cnt;
  logic [2:0]    w_cnt_nxt;
  logic [AW-1:0] r_idx;
  logic          r_write;
  logic [7:0]    r_mem [MEM_DEPTH];

  logic w_open;
  logic w_accept;
  logic w_err;
  logic w_commit;
  logic w_unused;

  // New address phases are only taken in cycles that end a data phase.
  assign w_open = (r_state == ST_IDLE)
                | (r_state == ST_DATA)
                | (r_state == ST_ERR2);

  assign w_accept = w_open & io_ahb.hsel
                  & io_ahb.htrans[1] & io_ahb.hready;

  assign w_err = ({1'b0, io_ahb.haddr} >= LP_DEPTH)
               | (io_ahb.hsize != HSIZE_BYTE);

  assign w_commit = (r_state == ST_DATA) & r_write;

  assign w_unused = ^{io_ahb.hburst, io_ahb.hprot};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_WAIT: begin
        if (r_cnt == 3'd0) w_state_nxt = ST_DATA;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_accept) begin
      if (w_err) begin
        w_state_nxt = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = LP_WLOAD;
      end else begin
        w_state_nxt = ST_DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_idx   <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx   <= io_ahb.haddr[AW-1:0];
        r_write <= io_ahb.hwrite;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_commit) begin
      r_mem[r_idx] <= io_ahb.hwdata;
    end
  end

  assign io_ahb.hreadyout = ~((r_state == ST_WAIT)
                            | (r_state == ST_ERR1));

  assign io_ahb.hresp =
    ((r_state == ST_ERR1) | (r_state == ST_ERR2))
      ? HRESP_ERROR : HRESP_OKAY;

  // Combinational read lets a read right after a write see the new byte.
  assign io_ahb.hrdata =
    ((r_state == ST_DATA) & ~r_write) ? r_mem[r_idx] : 8'h00;

endmodule

// File: doc/ahb_lite_mem_slave.md
# ahb_lite_mem_slave

AHB-Lite responder (slave) backing the dcache AHB master with a small on-chip byte memory. It replaces the fixed-pattern memory stub: it decodes address-phase transfers, inserts a programmable number of wait states, and commits writes or returns read data in the data phase. Out-of-range addresses and unsupported sizes get the standard two-cycle ERROR response.

## Interface
- WAIT_STATES, 1, data-phase wait cycles per OKAY transfer (0..7)
- MEM_DEPTH, 16, number of byte locations; valid addresses are 0..MEM_DEPTH-1
- ADDR_LENGTH, 8, haddr width
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- hsel  input  1  slave select
- haddr  input  ADDR_LENGTH  address-phase address
- htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  input  1  1=write, 0=read
- hsize  input  3  only 3'b000 (byte) is legal
- hburst  input  3  ignored; every beat is handled as a single transfer
- hprot  input  4  ignored
- hwdata  input  8  write data, valid in the write data phase
- hready  input  1  bus HREADY (previous data phase completes)
- hreadyout  output  1  slave ready; reset 1
- hrdata  output  8  read data; reset 0x00
- hresp  output  1  0=OKAY, 1=ERROR; reset 0

## Operation
- Accept: an address phase is taken when hsel & htrans[1] & hready at the rising edge. Register haddr, hwrite and an error flag. err = (haddr >= MEM_DEPTH) | (hsize != 0).
- IDLE/BUSY, or hsel=0, with hready=1: no data phase follows. The slave holds hreadyout=1, hresp=0 (zero-wait OKAY).
- States:
  - ST_IDLE: no pending data phase. hreadyout=1, hresp=0. On accept: go to ST_ERR1 if err; else go to ST_WAIT if WAIT_STATES>0 (load wait counter = WAIT_STATES-1); else go to ST_DATA.
  - ST_WAIT: hreadyout=0, hresp=0. Counter decrements each cycle. Go to ST_DATA when the counter is 0. No accept in this state, since hready is low.
  - ST_DATA: final OKAY cycle. hreadyout=1, hresp=0. A write commits hwdata to mem[addr_q] at the end of the cycle. A read drives hrdata = mem[addr_q]. A new accept in this cycle follows the same branching as ST_IDLE; otherwise go to ST_IDLE.
  - ST_ERR1: hreadyout=0, hresp=1. Always go to ST_ERR2.
  - ST_ERR2: hreadyout=1, hresp=1. No memory write. Accept/branch as ST_DATA; otherwise go to ST_IDLE.
- hrdata is 0x00 in every state except a read in ST_DATA.
- A write that errors never modifies memory. A read that errors returns hrdata=0x00.
- Address width: the index uses the low $clog2(MEM_DEPTH) bits of addr_q, and only after the range check passes.
- Memory array is cleared to 0x00 on reset.

## Timing
- OKAY latency: the data phase lasts WAIT_STATES+1 cycles after the address-phase edge. hreadyout is low for exactly WAIT_STATES cycles.
- ERROR: always 2 data-phase cycles, regardless of WAIT_STATES.
- Back-to-back transfers: an address phase overlapping ST_DATA or ST_ERR2 is accepted with no bubble.
- Write then read of the same address, back-to-back: the read data phase returns the newly written byte. This works because the write commits at the edge that ends the write data phase, and hrdata is combinational from the array.
- Reset mid-transfer: the slave returns asynchronously to ST_IDLE, hreadyout=1, hresp=0, hrdata=0x00. The pending write is dropped and the memory is cleared.
- hsel deasserted during a data phase does not abort it; the data phase completes normally.

## Structure
- Shared package ahb_pkg holds:
  - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ)
  - HRESP_OKAY/HRESP_ERROR constants
  - HSIZE_BYTE constant
- The slave state enum (ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2) is local to the module.
- No sub-module is needed. The memory array, wait counter and FSM are all inline.

## Test plan
- WAIT_STATES=1: NONSEQ write haddr=0x05, hwdata=0xA5, then NONSEQ read 0x05. Required: hreadyout low for 1 cycle in each data phase; read hrdata=0xA5; hresp=0 throughout.
- WAIT_STATES=0: back-to-back write 0x03=0x3C followed immediately by read 0x03. Required: no wait cycles; read data phase returns 0x3C.
- Read haddr=0x10 with MEM_DEPTH=16. Required: hresp=1 with hreadyout=0, then hresp=1 with hreadyout=1; hrdata=0x00; then ST_IDLE.
- Write 0x02 with hsize=3'b001. Required: two-cycle ERROR; a subsequent read of 0x02 returns 0x00.
- htrans=IDLE with hsel=1, then BUSY. Required: hreadyout=1, hresp=0; no memory change.
- Assert rst_n low during ST_WAIT of a write of 0x7E to 0x01. Required: outputs return to their reset values immediately; after release, a read of 0x01 returns 0x00.
